// File: rtl/program_counter_if.sv
// Program counter bus: next-PC request from the fetch logic, and the
// current PC with its derived status returned by the PC register block.
interface program_counter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus4;
    logic             misaligned;

    // Fetch side drives the next PC and observes the current one.
    modport master (
        output pc_in,
        input  pc_out,
        input  pc_plus4,
        input  misaligned
    );

    // PC register side.
    modport slave (
        input  pc_in,
        output pc_out,
        output pc_plus4,
        output misaligned
    );
endinterface

// File: rtl/program_counter.sv
// Program counter register. Loads pc_in on every rising edge, exposes the
// current PC, its sequential successor (+4) and a word-misalignment flag.
// The outputs depend only on the register, so there is no combinational
// path from pc_in to any output.
module program_counter #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    program_counter_if.slave  pc_bus
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_reg;

    // PC register: async reset to the vector, otherwise load pc_in verbatim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_bus.pc_in;
        end
    end

    // Outputs derived purely from the register; the add wraps modulo 2^WIDTH.
    always_comb begin
        pc_bus.pc_out     = pc_reg;
        pc_bus.pc_plus4   = pc_reg + PC_STEP;
        pc_bus.misaligned = |pc_reg[1:0];
    end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset behaviour, load latency,
// wrap-around of pc_plus4 and the misaligned flag.
module tb_program_counter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    program_counter_if #(.WIDTH(32)) pc_bus ();

    program_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_bus (pc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Scenario 1: reset high at start, release at 10 ns, check at 20 ns.
        reset        = 1'b1;
        pc_bus.pc_in = 32'hDEAD_BEEF;
        #2;
        chk("rst_pc_out",   pc_bus.pc_out,            32'h0000_0000);
        chk("rst_plus4",    pc_bus.pc_plus4,          32'h0000_0004);
        chk("rst_misalign", {31'b0, pc_bus.misaligned}, 32'd0);
        #8;
        reset = 1'b0;
        #10;
        chk("s1_pc_out",   pc_bus.pc_out,            32'hDEAD_BEEF);
        chk("s1_misalign", {31'b0, pc_bus.misaligned}, 32'd1);
        chk("s1_plus4",    pc_bus.pc_plus4,          32'hDEAD_BEF3);

        // Scenario 2: reset asserted mid-cycle, held over several edges.
        #1;
        reset        = 1'b1;
        pc_bus.pc_in = 32'h1234_5678;
        #1;
        chk("s2_async_clear", pc_bus.pc_out, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #2;
        chk("s2_hold_pc_out",   pc_bus.pc_out,            32'h0000_0000);
        chk("s2_hold_plus4",    pc_bus.pc_plus4,          32'h0000_0004);
        chk("s2_hold_misalign", {31'b0, pc_bus.misaligned}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("s2_first_load", pc_bus.pc_out,   32'h1234_5678);
        chk("s2_plus4",      pc_bus.pc_plus4, 32'h1234_567C);

        // Scenario 3: successive loads with one-cycle latency.
        pc_bus.pc_in = 32'h0000_0100;
        @(posedge clk);
        #2;
        chk("s3_load_100", pc_bus.pc_out, 32'h0000_0100);
        chk("s3_mis_100",  {31'b0, pc_bus.misaligned}, 32'd0);
        pc_bus.pc_in = 32'h0000_0104;
        #1;
        chk("s3_no_comb_path", pc_bus.pc_out, 32'h0000_0100);
        @(posedge clk);
        #2;
        chk("s3_load_104", pc_bus.pc_out, 32'h0000_0104);
        pc_bus.pc_in = 32'h0000_0200;
        @(posedge clk);
        #2;
        chk("s3_load_200",  pc_bus.pc_out,   32'h0000_0200);
        chk("s3_plus4_200", pc_bus.pc_plus4, 32'h0000_0204);
        chk("s3_mis_200",   {31'b0, pc_bus.misaligned}, 32'd0);

        // Scenario 5: reset between edges with pc_out = 0x200.
        #2;
        reset        = 1'b1;
        pc_bus.pc_in = 32'hABCD_0000;
        #1;
        chk("s5_async_clear", pc_bus.pc_out, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #2;
        chk("s5_hold",  pc_bus.pc_out,   32'h0000_0000);
        chk("s5_plus4", pc_bus.pc_plus4, 32'h0000_0004);
        reset        = 1'b0;
        pc_bus.pc_in = 32'h0000_0300;
        @(posedge clk);
        #2;
        chk("s5_first_load", pc_bus.pc_out, 32'h0000_0300);

        // Reload of the same value.
        @(posedge clk);
        #2;
        chk("same_reload", pc_bus.pc_out, 32'h0000_0300);

        // Scenario 4: wrap-around of pc_plus4.
        pc_bus.pc_in = 32'hFFFF_FFFC;
        @(posedge clk);
        #2;
        chk("s4_pc_out",   pc_bus.pc_out,   32'hFFFF_FFFC);
        chk("s4_wrap",     pc_bus.pc_plus4, 32'h0000_0000);
        chk("s4_misalign", {31'b0, pc_bus.misaligned}, 32'd0);

        // Scenario 6 and further misaligned values, loaded verbatim.
        pc_bus.pc_in = 32'h0000_0002;
        @(posedge clk);
        #2;
        chk("s6_pc_out",   pc_bus.pc_out,   32'h0000_0002);
        chk("s6_misalign", {31'b0, pc_bus.misaligned}, 32'd1);
        chk("s6_plus4",    pc_bus.pc_plus4, 32'h0000_0006);
        pc_bus.pc_in = 32'h0000_0003;
        @(posedge clk);
        #2;
        chk("mis3_pc_out",   pc_bus.pc_out,   32'h0000_0003);
        chk("mis3_misalign", {31'b0, pc_bus.misaligned}, 32'd1);
        pc_bus.pc_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        chk("ones_pc_out", pc_bus.pc_out,   32'hFFFF_FFFF);
        chk("ones_wrap",   pc_bus.pc_plus4, 32'h0000_0003);
        pc_bus.pc_in = 32'h8000_0001;
        @(posedge clk);
        #2;
        chk("mis1_pc_out",   pc_bus.pc_out,   32'h8000_0001);
        chk("mis1_misalign", {31'b0, pc_bus.misaligned}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
